seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul.sv | 120 ++++++++++++
 tb/tb_seq_mul.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial-product step per cycle, WIDTH steps per operation.
// Optional signed support is compiled in with SIGNED_MODE_EN; without it sign_mode is ignored.
module seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 sign_mode,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               r_state, w_state_d;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_d;
  logic [WIDTH-1:0]     r_mplier, w_mplier_d;
  logic [2*WIDTH-1:0]   r_acc, w_acc_d;
  logic [CW-1:0]        r_cnt, w_cnt_d;
  logic                 r_neg, w_neg_d;
  logic [2*WIDTH-1:0]   r_out, w_out_d;

  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]   w_sum;
  logic [2*WIDTH-1:0]   w_prod;

`ifdef SIGNED_MODE_EN
  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign w_a_neg = sign_mode & in_a[WIDTH-1];
  assign w_b_neg = sign_mode & in_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -in_a : in_a;
  assign w_b_mag = w_b_neg ? -in_b : in_b;
  assign w_prod  = r_neg ? -w_sum : w_sum;
`else
  logic w_unused_sign_mode;
  assign w_unused_sign_mode = sign_mode;
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
  assign w_a_mag = in_a;
  assign w_b_mag = in_b;
  assign w_prod  = w_sum;
`endif

  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_acc    <= w_acc_d;
      r_cnt    <= w_cnt_d;
      r_neg    <= w_neg_d;
      r_out    <= w_out_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_acc_d    = r_acc;
    w_cnt_d    = r_cnt;
    w_neg_d    = r_neg;
    w_out_d    = r_out;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d  = StRun;
          w_mcand_d  = {{WIDTH{1'b0}}, w_a_mag};
          w_mplier_d = w_b_mag;
          w_neg_d    = w_a_neg ^ w_b_neg;
          w_acc_d    = '0;
          w_cnt_d    = '0;
        end
      end
      StRun: begin
        w_acc_d    = w_sum;
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_cnt_d    = r_cnt + CW'(1);
        if (r_cnt == LastStep) begin
          w_state_d = StDone;
          w_out_d   = w_prod;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign busy      = (r_state != StIdle);
  assign out_valid = (r_state == StDone);
  assign out       = r_out;

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul: an 8-bit instance for most checks and a 16-bit
// instance for the wide corner case; signed expectations depend on SIGNED_MODE_EN.
module tb_seq_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_a, in_b;
  logic        sign_mode;
  logic        busy;
  logic [15:0] out;
  logic        out_valid;

  logic        start16;
  logic [15:0] in_a16, in_b16;
  logic        busy16;
  logic [31:0] out16;
  logic        out_valid16;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul #(.WIDTH(8)) u_dut8 (
    .CLK       (clk),
    .reset     (rst_n),
    .start     (start),
    .in_a      (in_a),
    .in_b      (in_b),
    .sign_mode (sign_mode),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid)
  );

  seq_mul #(.WIDTH(16)) u_dut16 (
    .CLK       (clk),
    .reset     (rst_n),
    .start     (start16),
    .in_a      (in_a16),
    .in_b      (in_b16),
    .sign_mode (1'b0),
    .busy      (busy16),
    .out       (out16),
    .out_valid (out_valid16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the 8-bit DUT idle. lat counts edges from the start drive,
  // the accepting edge being edge 1, up to the first sample showing out_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] prod, output int lat);
    in_a = a;
    in_b = b;
    sign_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = out;
  endtask

  initial begin
    logic [15:0] prod;
    int          lat;
    int          nvalid;
    int          vedge;

    rst_n = 1'b0;
    start = 1'b0;
    in_a = '0;
    in_b = '0;
    sign_mode = 1'b0;
    start16 = 1'b0;
    in_a16 = '0;
    in_b16 = '0;
    #1;
    check("rst_out", 64'(out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 3*9: accepted on the first edge after reset release
    run8(8'd3, 8'd9, 1'b0, prod, lat);
    check("3x9_out", 64'(prod), 64'd27);
    check("3x9_lat", 64'(lat), 64'd9);
    @(posedge clk);
    #1;
    check("3x9_busy_after", 64'(busy), 64'd0);
    check("3x9_valid_pulse", 64'(out_valid), 64'd0);
    check("3x9_out_held", 64'(out), 64'd27);

    run8(8'd255, 8'd255, 1'b0, prod, lat);
    check("255x255_out", 64'(prod), 64'd65025);
    @(posedge clk);
    #1;

    run8(8'd0, 8'd3, 1'b0, prod, lat);
    check("0x3_out", 64'(prod), 64'd0);
    check("0x3_lat", 64'(lat), 64'd9);
    @(posedge clk);
    #1;

`ifdef SIGNED_MODE_EN
    run8(8'hF6, 8'd14, 1'b1, prod, lat);
    check("s_m10x14", 64'(prod), 64'hFF74);
    @(posedge clk);
    #1;
    run8(8'h80, 8'h80, 1'b1, prod, lat);
    check("s_m128xm128", 64'(prod), 64'd16384);
    @(posedge clk);
    #1;
    run8(8'h7F, 8'h81, 1'b1, prod, lat);
    check("s_127xm127", 64'(prod), 64'hC0FF);
    @(posedge clk);
    #1;
`else
    run8(8'hF6, 8'd14, 1'b1, prod, lat);
    check("u_246x14", 64'(prod), 64'h0D74);
    @(posedge clk);
    #1;
    run8(8'h7F, 8'h81, 1'b1, prod, lat);
    check("u_127x129", 64'(prod), 64'h3FFF);
    @(posedge clk);
    #1;
`endif
    run8(8'hF6, 8'd14, 1'b0, prod, lat);
    check("u_sm0_246x14", 64'(prod), 64'h0D74);
    @(posedge clk);
    #1;

    // start held high, operands changed mid-run
    in_a = 8'd5;
    in_b = 8'd6;
    sign_mode = 1'b0;
    start = 1'b1;
    nvalid = 0;
    vedge = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) begin
        in_a = 8'd7;
        in_b = 8'd7;
      end
      if (e == 10) check("held_idle_busy", 64'(busy), 64'd0);
      if (e == 11) check("held_reaccept_busy", 64'(busy), 64'd1);
      if (out_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          check("held_first_out", 64'(out), 64'd30);
          check("held_first_edge", 64'(e), 64'd9);
        end else begin
          vedge = e;
          check("held_second_out", 64'(out), 64'd49);
        end
      end
    end
    start = 1'b0;
    check("held_valid_count", 64'(nvalid), 64'd2);
    check("held_second_edge", 64'(vedge), 64'd19);

    // reset during RUN step 4
    in_a = 8'd200;
    in_b = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out", 64'(out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    #2;
    rst_n = 1'b1;
    nvalid = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) nvalid++;
    end
    check("abort_no_valid", 64'(nvalid), 64'd0);
    run8(8'd123, 8'd7, 1'b0, prod, lat);
    check("123x7_out", 64'(prod), 64'd861);
    check("123x7_lat", 64'(lat), 64'd9);
    @(posedge clk);
    #1;

    // 16-bit instance
    in_a16 = 16'hFFFF;
    in_b16 = 16'hFFFF;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w16_out", 64'(out16), 64'hFFFE0001);
    check("w16_lat", 64'(lat), 64'd17);
    @(posedge clk);
    #1;
    check("w16_busy_after", 64'(busy16), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
